// File: rtl/trace_buf.sv
// trace_buf: circular debug trace of {pc, instr, arg, acc}, frozen POST records after a PC match, read oldest-first.
// Optional TRACE_BUF_TRIG_MASK_EN adds a trig_mask input for masked PC matching.
module trace_buf #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int POST   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   pc,
    input  logic [WIDTH-1:0]   instr,
    input  logic [WIDTH-1:0]   arg,
    input  logic [WIDTH-1:0]   acc,
    input  logic               arm,
    input  logic [WIDTH-1:0]   trig_pc,
`ifdef TRACE_BUF_TRIG_MASK_EN
    input  logic [WIDTH-1:0]   trig_mask,
`endif
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [4*WIDTH-1:0] rd_data,
    output logic [ADDR_W:0]    fill,
    output logic [1:0]         state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_CNT = ADDR_W'(POST);

    logic [4*WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr, cnt, wr_nxt, first;
    logic [ADDR_W:0]    fill_nxt;
    logic               match, we;

`ifdef TRACE_BUF_TRIG_MASK_EN
    assign match = (pc & trig_mask) == (trig_pc & trig_mask);
`else
    assign match = pc == trig_pc;
`endif

    // arm wins over any write, including a same-cycle trigger record
    assign we       = (state == S_ARMED || state == S_POST) && !arm;
    assign wr_nxt   = wr_ptr + 1'b1;
    assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;
    assign first    = wr_nxt - fill_nxt[ADDR_W-1:0];
    assign rd_valid = state == S_DONE && fill != '0;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (we) mem[wr_ptr] <= {pc, instr, arg, acc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else if (arm) begin
            state  <= S_ARMED;
            wr_ptr <= '0;
            fill   <= '0;
            cnt    <= '0;
        end else if (we) begin
            wr_ptr <= wr_nxt;
            fill   <= fill_nxt;
            if (state == S_ARMED && match) begin
                state  <= (POST == 0) ? S_DONE : S_POST;
                cnt    <= POST_CNT;
                rd_ptr <= first;
            end else if (state == S_POST) begin
                cnt <= cnt - 1'b1;
                if (cnt == ADDR_W'(1)) begin
                    state  <= S_DONE;
                    rd_ptr <= first;
                end
            end
        end else if (state == S_DONE) begin
            if (rd_valid && rd_ready) begin
                rd_ptr <= rd_ptr + 1'b1;
                fill   <= fill - 1'b1;
                if (fill == (ADDR_W+1)'(1)) state <= S_IDLE;
            end else if (fill == '0) begin
                state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_trace_buf.sv
// tb_trace_buf: directed checks of capture, trigger, wrap, backpressure, arm restart and async reset.
module tb_trace_buf;
    logic        clk = 0;
    logic        rst = 0;
    logic [7:0]  pc = 0, instr = 0, arg = 0, acc = 0, trig_pc = 0;
    logic        arm = 0, rd_ready = 0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [4:0]  fill;
    logic [1:0]  state;
    int          n = 0, errs = 0;
`ifdef TRACE_BUF_TRIG_MASK_EN
    logic [7:0]  trig_mask = 8'hFF;
`endif

    trace_buf dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .arg(arg), .acc(acc),
        .arm(arm), .trig_pc(trig_pc),
`ifdef TRACE_BUF_TRIG_MASK_EN
        .trig_mask(trig_mask),
`endif
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .fill(fill), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rec(input logic [7:0] v);
        logic [7:0] a, b;
        a = v + 8'd1;
        b = v + 8'd2;
        return {v, a, b, ~v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [7:0] v);
        pc    = v;
        instr = v + 8'd1;
        arg   = v + 8'd2;
        acc   = ~v;
    endtask

    task automatic arm_cap(input logic [7:0] t);
        trig_pc = t;
        arm = 1;
        tick();
        arm = 0;
    endtask

    task automatic feed(input logic [7:0] start, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            set_pc(8'(start + i));
            tick();
        end
    endtask

    task automatic drain(input logic [7:0] start, input int cnt);
        rd_ready = 1;
        for (int i = 0; i < cnt; i++) begin
            chk("rd_valid", 32'(rd_valid), 32'd1);
            chk("rd_data", rd_data, rec(8'(start + i)));
            tick();
        end
        rd_ready = 0;
        chk("end_state", 32'(state), 32'd0);
        chk("end_fill", 32'(fill), 32'd0);
        chk("end_valid", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_data", rd_data, 32'd0);
        rst = 1;
        tick();

        // basic capture: trigger at pc=5, three post records
        arm_cap(8'd5);
        chk("armed_state", 32'(state), 32'd1);
        feed(8'd0, 8);
        chk("post_state", 32'(state), 32'd2);
        feed(8'd8, 1);
        chk("done_state", 32'(state), 32'd3);
        chk("done_fill", 32'(fill), 32'd9);
        feed(8'd9, 2);
        chk("frozen_fill", 32'(fill), 32'd9);
        drain(8'd0, 9);

        // wrap-around: 24 writes into 16 slots
        arm_cap(8'd20);
        feed(8'd0, 24);
        chk("wrap_state", 32'(state), 32'd3);
        chk("wrap_fill", 32'(fill), 32'd16);
        drain(8'd8, 16);

        // backpressure then alternating ready, ending with async reset at fill=6
        arm_cap(8'd5);
        feed(8'd0, 9);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rd_valid), 32'd1);
            chk("bp_data", rd_data, rec(8'd0));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            rd_ready = 1;
            tick();
            rd_ready = 0;
            chk("alt_data", rd_data, rec(8'(k + 1)));
            chk("alt_fill", 32'(fill), 32'(8 - k));
            tick();
            chk("alt_hold", rd_data, rec(8'(k + 1)));
        end
        chk("pre_rst_fill", 32'(fill), 32'd6);
        #3 rst = 0;
        #1;
        chk("arst_valid", 32'(rd_valid), 32'd0);
        chk("arst_data", rd_data, 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_fill", 32'(fill), 32'd0);
        rst = 1;
        rd_ready = 1;
        tick();
        tick();
        chk("idle_ready_state", 32'(state), 32'd0);
        chk("idle_ready_fill", 32'(fill), 32'd0);
        chk("idle_ready_valid", 32'(rd_valid), 32'd0);
        rd_ready = 0;

        // arm during POST restarts capture
        arm_cap(8'd5);
        feed(8'd0, 8);
        chk("mid_post_state", 32'(state), 32'd2);
        set_pc(8'd8);
        arm = 1;
        tick();
        arm = 0;
        chk("rearm_state", 32'(state), 32'd1);
        chk("rearm_fill", 32'(fill), 32'd0);
        chk("rearm_valid", 32'(rd_valid), 32'd0);
        feed(8'd0, 9);
        chk("rearm_done", 32'(state), 32'd3);
        chk("rearm_done_fill", 32'(fill), 32'd9);
        drain(8'd0, 9);

        // arm and trigger match in the same cycle: arm wins, nothing written
        arm_cap(8'd5);
        feed(8'd0, 3);
        set_pc(8'd5);
        arm = 1;
        tick();
        arm = 0;
        chk("armtrig_state", 32'(state), 32'd1);
        chk("armtrig_fill", 32'(fill), 32'd0);
        feed(8'd0, 9);
        chk("armtrig_fill2", 32'(fill), 32'd9);
        drain(8'd0, 9);

`ifdef TRACE_BUF_TRIG_MASK_EN
        trig_mask = 8'hF0;
        arm_cap(8'h17);
        feed(8'h0C, 8);
        chk("mask_state", 32'(state), 32'd3);
        chk("mask_fill", 32'(fill), 32'd8);
        drain(8'h0C, 8);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
